// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the MEM stage and a
// word-wide, little-endian data memory. Sub-word stores are done as
// read-modify-write; misaligned, out-of-range and illegal-size requests
// complete with err and never touch memory.

// One byte lane of the store merge: keeps the old byte or takes the
// matching byte of the store data, depending on size and offset.
module mem_access_lane #(
    parameter int LANE = 0
) (
    input  logic [7:0]  old_byte,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [7:0]  new_byte
);
    localparam logic [1:0] LID = LANE[1:0];

    // select between the buffered byte and the store byte for this lane
    always_comb begin
        new_byte = old_byte;
        case (size)
            2'b00:   if (offset == LID)       new_byte = wdata[7:0];
            2'b01:   if (offset[1] == LID[1]) new_byte = wdata[8*(LANE%2) +: 8];
            2'b10:                            new_byte = wdata[8*LANE +: 8];
            default: new_byte = old_byte;
        endcase
    end
endmodule

module mem_access_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_writeMem,
    input  logic [31:0] mem_data
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q, sext_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, buf_q;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        req_err;
    logic [31:0] shifted, load_val;
    logic [NUM_LANES-1:0][7:0] merged;

    // request validity: size, alignment and a 33-bit range check so that
    // addresses near the top of the 32-bit space cannot wrap into range
    always_comb begin
        case (size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        end_addr = {1'b0, addr} + 33'(nbytes);
        req_err  = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (addr[1:0] != 2'b00))
                 | (end_addr > 33'(MEM_BYTES));
    end

    // load extraction straight from the memory word read in ACCESS
    always_comb begin
        shifted  = '0;
        load_val = '0;
        case (size_q)
            2'b00: begin
                shifted  = mem_data >> {addr_q[1:0], 3'b000};
                load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                shifted  = mem_data >> {addr_q[1], 4'b0000};
                load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            end
            default: load_val = mem_data;
        endcase
    end

    // store merge: one lane instance per byte of the buffered word
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mem_access_lane #(.LANE(l)) u_lane (
            .old_byte (buf_q[8*l +: 8]),
            .wdata    (wdata_q),
            .size     (size_q),
            .offset   (addr_q[1:0]),
            .new_byte (merged[l])
        );
    end

    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_writeData = (state == WRITE) ? merged : '0;
    assign err           = done & err_q;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and state-decoded handshake / write strobe
    always_comb begin
        state_nx     = state;
        ready        = 1'b0;
        done         = 1'b0;
        mem_writeMem = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nx = req_err ? RESP : ACCESS;
            end
            ACCESS: state_nx = we_q ? WRITE : RESP;
            WRITE: begin
                mem_writeMem = 1'b1;
                state_nx     = RESP;
            end
            RESP: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request latch, read buffer, and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q    <= we;
                    sext_q  <= sext;
                    size_q  <= size;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    err_q   <= req_err;
                    if (req_err) rdata <= '0;
                end
                ACCESS: begin
                    buf_q <= mem_data;
                    if (!we_q) rdata <= load_val;
                end
                WRITE: rdata <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-level reference memory.
module tb_mem_access_unit;
    localparam int MEM_BYTES = 128;
    localparam int WORDS = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, done, err, mem_writeMem;
    logic [31:0] rdata, mem_addr, mem_writeData, mem_data;

    logic [31:0] tbmem   [WORDS];
    logic [31:0] ref_mem [WORDS];

    typedef struct {logic e; logic [31:0] rd; int cyc;} exp_t;
    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int cyc = 0;
    int compared = 0, mismatched = 0;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_writeData(mem_writeData),
        .mem_writeMem(mem_writeMem), .mem_data(mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data memory: combinational read, write on rising edge
    assign mem_data = tbmem[mem_addr[6:2]];
    always @(posedge clk) if (mem_writeMem) tbmem[mem_addr[6:2]] <= mem_writeData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: byte-addressed memory semantics from the access rules
    function automatic void model(input logic w, input logic [1:0] s, input logic x,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic e, output logic [31:0] rd,
                                  output logic wr, output logic [31:0] ww);
        int nb, idx, off;
        logic [31:0] word, val;
        logic [63:0] m;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        rd = '0; wr = 1'b0; ww = '0;
        if (nb == 0) e = 1'b1;
        else e = ((a % nb) != 0) || (({32'b0, a} + 64'(nb)) > 64'(MEM_BYTES));
        if (e) return;
        idx  = int'(a / 4);
        off  = int'(a % 4);
        word = ref_mem[idx];
        if (w) begin
            ww = word;
            for (int i = 0; i < nb; i++) ww[8*(off+i) +: 8] = d[8*i +: 8];
            ref_mem[idx] = ww;
            wr = 1'b1;
        end else begin
            val = word >> (8*off);
            m   = (64'd1 << (8*nb)) - 64'd1;
            rd  = val & m[31:0];
            if (x && nb < 4 && val[8*nb-1]) rd = rd | ~m[31:0];
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            compared++; mismatched++;
            $display("FAIL ready_timeout: ready=%b expected 1", ready);
        end
    endtask

    // drive one request at a negedge; expectation pushed before the accepting edge
    task automatic issue(input logic w, input logic [1:0] s, input logic x,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t ex;
        wr_t  wx;
        logic e, wr;
        logic [31:0] rd, ww;
        wait_ready();
        model(w, s, x, a, d, e, rd, wr, ww);
        ex.e = e; ex.rd = rd;
        ex.cyc = cyc + 1 + (e ? 0 : (w ? 2 : 1));
        exp_q.push_back(ex);
        if (wr) begin
            wx.a = {a[31:2], 2'b00}; wx.d = ww;
            wr_q.push_back(wx);
        end
        req = 1'b1; we = w; size = s; sext = x; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    // monitor: pops expectations whenever the DUT completes or writes
    always @(negedge clk) begin
        exp_t ex;
        wr_t  wx;
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL done_unexpected: done=1 expected no completion");
                end else begin
                    ex = exp_q.pop_front();
                    chk("err", 32'(err), 32'(ex.e));
                    chk("rdata", rdata, ex.rd);
                    chk("done_cycle", cyc, ex.cyc);
                end
            end else if (err) begin
                chk("err_without_done", 32'(err), 32'd0);
            end
            if (mem_writeMem) begin
                if (wr_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL write_unexpected: mem_writeMem=1 at %h expected 0", mem_addr);
                end else begin
                    wx = wr_q.pop_front();
                    chk("wr_addr", mem_addr, wx.a);
                    chk("wr_data", mem_writeData, wx.d);
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_writeData, 32'd0);
        chk({tag, "_wmem"}, 32'(mem_writeMem), 32'd0);
    endtask

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int r, n;
        for (int i = 0; i < WORDS; i++) tbmem[i] = $urandom;
        tbmem[0] = 32'h8899AABB;
        tbmem[1] = 32'h11F27F00;
        tbmem[2] = 32'hAABBCCDD;
        tbmem[4] = 32'h0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = tbmem[i];

        #3 chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // directed cases
        issue(0, 2'b10, 0, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h6, 0);
        issue(0, 2'b00, 0, 32'h6, 0);
        issue(0, 2'b01, 1, 32'h6, 0);
        issue(1, 2'b01, 0, 32'hA, 32'hFFFF1234);
        issue(0, 2'b10, 0, 32'h8, 0);
        issue(0, 2'b01, 0, 32'h3, 0);
        issue(0, 2'b11, 0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h7C, 0);
        issue(0, 2'b10, 0, 32'h80, 0);
        issue(0, 2'b00, 0, 32'hFFFFFFFF, 0);
        issue(1, 2'b10, 0, 32'h7E, 32'h1);

        // reset pulsed while the RMW write is pending
        wait_ready();
        req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h10; wdata = 32'hEE;
        @(posedge clk);
        @(posedge clk);
        #1 req = 1'b0;
        chk("in_write_wmem", 32'(mem_writeMem), 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("word10_unwritten", tbmem[4], 32'd0);
        issue(0, 2'b10, 0, 32'h10, 0);

        // busy rejection: request held while ready=0 must be ignored
        issue(0, 2'b10, 0, 32'h0, 0);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        issue(0, 2'b10, 0, 32'h0, 0);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            s = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 15);
            if (r < 12)      a = $urandom_range(0, MEM_BYTES - 1);
            else if (r < 14) a = $urandom_range(MEM_BYTES - 4, MEM_BYTES + 7);
            else             a = 32'hFFFFFFF8 + $urandom_range(0, 7);
            if ($urandom_range(0, 1) && s != 2'b11) a = a & ~((32'd1 << s) - 32'd1);
            issue($urandom_range(0, 1), s, $urandom_range(0, 1), a, $urandom);
        end

        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pending_done", exp_q.size(), 0);
        chk("pending_write", wr_q.size(), 0);
        for (int i = 0; i < WORDS; i++) chk("final_mem", tbmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store controller connecting the CPU's memory stage to the byte-addressed, little-endian, word-wide data memory (combinational read, write on rising clock edge). Accepts byte/halfword/word load and store requests and performs sub-word extraction with optional sign extension. Implements sub-word stores as read-modify-write over the memory's word-only write port, and detects misaligned and out-of-range accesses. Sits between the MEM pipeline stage and the data memory.

## Interface
- MEM_BYTES, 128, memory size in bytes; multiple of 4
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal (treated as error)
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; byte/half stores use the low 8/16 bits
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = misaligned, out-of-range or illegal size
- rdata  out  32  load result; valid with done and held until the next done
- mem_addr  out  32  word-aligned address to data memory
- mem_writeData  out  32  merged write word
- mem_writeMem  out  1  write enable to data memory
- mem_data  in  32  combinational read data from data memory

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: ready=1. On req, latch we, size, sext, addr, wdata.
  - Error check: size=11; half with addr[0]=1; word with addr[1:0]≠00; addr+bytes > MEM_BYTES. On error, go to RESP with err=1; no memory access occurs.
  - Otherwise go to ACCESS.
- ACCESS: mem_addr = {addr[31:2],2'b00}; mem_writeMem=0; latch mem_data into a word buffer. Load → RESP. Store → WRITE.
- WRITE: mem_writeMem=1 for exactly one cycle. mem_writeData = buffer with the selected lanes replaced:
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes 2·addr[1] and 2·addr[1]+1 ← wdata[15:0].
  - Word: wdata.
  - Then go to RESP.
- RESP: done=1 for one cycle, then go to IDLE.
- Load result, registered on entry to RESP. Byte k = buffer[8k+7:8k].
  - Byte: lane addr[1:0].
  - Half: buffer[16·addr[1]+15 : 16·addr[1]].
  - Extension: sext=1 replicates the MSB; sext=0 fills with zeros.
  - Stores and errors set rdata to 0.
- mem_writeMem is decoded from state. In every state other than WRITE it is 0.
- req while ready=0: ignored, not queued.

## Timing
- Reset values (async, immediate): state=IDLE, ready=1, done=0, err=0, rdata=0, mem_addr=0, mem_writeData=0, mem_writeMem=0.
- Request accepted at edge E0 (req=1, ready=1).
- Load: ACCESS in the cycle after E0; done=1 in the cycle after E0+1. ready returns after E0+2.
- Store: ACCESS, then WRITE; memory updated at the edge ending WRITE (E0+2); done=1 in the cycle after E0+2.
- Error: done=1, err=1 in the cycle after E0; no mem_writeMem pulse.
- Back-to-back: next request accepted at the first edge where ready=1. Minimum throughput is one load per 3 cycles and one store per 4 cycles.
- Reset mid-transaction: the transaction is dropped. If reset is asserted during WRITE, mem_writeMem drops immediately, so no write occurs at the next edge. No done is produced for a dropped transaction.
- Address wrap: addr+bytes is computed in 33 bits, so addresses near 0xFFFFFFFF are flagged out-of-range rather than wrapping.

## Test plan
- Word load: memory word 0 = 0x8899AABB; req at addr=0x0 with size=10, we=0 → done 2 cycles later, rdata=0x8899AABB, err=0, mem_writeMem never 1.
- Byte load sign extension: word 4 = 0x11F27F00. Byte at 0x6 with sext=1 → 0xFFFFFFF2. Same byte with sext=0 → 0x000000F2. Half at 0x6 with sext=1 → 0x000011F2.
- Half store RMW: word 8 = 0xAABBCCDD; store half 0x1234 at 0xA → exactly one mem_writeMem pulse with mem_writeData=0x1234CCDD; a subsequent word load at 0x8 returns 0x1234CCDD.
- Misalignment, illegal size and range:
  - Half at 0x3 → done+err one cycle after acceptance, no memory activity.
  - size=11 at 0x0 → err.
  - Word load at 0x7C → ok; word load at 0x80 → err.
  - Byte load at 0xFFFFFFFF → err.
- Reset during WRITE: byte store of 0xEE to 0x10 (word 0x10 = 0) with reset pulsed during WRITE → mem_writeMem falls immediately, word 0x10 still reads 0. All outputs are at reset values and ready=1.
- Busy rejection: a second req while ready=0 is ignored, so exactly one done is seen. A new req accepted the cycle ready returns completes normally.
